cascade_inta_sequencer: RTL and testbench

- Clocked controller that sequences the 8086-mode two-pulse INTA handshake for one PIC instance, in single, cascade-master or cascade-slave mode.
- Raises INT, freezes the priority resolver and latches the winning level.
- Drives the CAS bus (master) or decodes it (slave), pulses ISR set, and decides when this device drives the vector on the data bus.
- Sits between the priority resolver / ISR and the cascade bus pins.

---
 rtl/cascade_pkg.sv | 15 +
 rtl/inta_edge_sync.sv | 28 ++
 rtl/cascade_inta_sequencer.sv | 148 ++++++++++++++
 tb/tb_cascade_inta_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cascade_pkg.sv
// Shared types and constants for the cascade INTA sequencer.
package cascade_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK1,
    GAP,
    ACK2
  } seq_state_t;

  localparam logic [2:0] CAS_IDLE       = 3'b000;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

endpackage

// File: rtl/inta_edge_sync.sv
// Synchronises the asynchronous INTA_N pin and produces one-cycle fall/rise pulses.
module inta_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], inta_n};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fall = prev_q & ~sync_q[SYNC_STAGES-1];
  assign rise = ~prev_q & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cascade_inta_sequencer.sv
// Two-pulse 8086 INTA sequencer for one PIC in single, cascade-master or cascade-slave mode.
// Optional automatic EOI output is built when PIC_AEOI_EN is defined.
//
//   state | meaning
//   IDLE  | no request outstanding
//   REQ   | INT raised, waiting for first INTA fall
//   ACK1  | first INTA low, level latched, resolver frozen
//   GAP   | between the two INTA pulses
//   ACK2  | second INTA low, vector driven if this device responds
module cascade_inta_sequencer
  import cascade_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sp,
  input  logic       sngl,
  input  logic [7:0] icw3,
  input  logic       irq_valid,
  input  logic [2:0] irq_level,
  input  logic       inta_n,
  input  logic [2:0] cas_in,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  output logic       intr,
  output logic       freeze,
  output logic       isr_set,
  output logic [2:0] isr_level,
  output logic       data_oe,
  output logic       abort
`ifdef PIC_AEOI_EN
  ,
  input  logic       aeoi,
  output logic       eoi_pulse
`endif
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

  seq_state_t       state;
  logic             fall, rise;
  logic             pending, selected;
  logic [CNT_W-1:0] tcount;
  logic             master, responder;
  logic [2:0]       new_level, new_cas, cur_cas;

  inta_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .inta_n (inta_n),
    .fall   (fall),
    .rise   (rise)
  );

  assign master    = sp & ~sngl;
  assign cas_oe    = master;
  assign new_level = irq_valid ? irq_level : SPURIOUS_LEVEL;
  assign new_cas   = (master && icw3[new_level]) ? new_level : CAS_IDLE;
  assign cur_cas   = (master && icw3[isr_level]) ? isr_level : CAS_IDLE;
  // A slave only answers when it was addressed and the request was genuine.
  assign responder = sngl | (sp & ~icw3[isr_level]) | (~sp & ~sngl & selected & pending);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      intr      <= 1'b0;
      freeze    <= 1'b0;
      isr_set   <= 1'b0;
      data_oe   <= 1'b0;
      abort     <= 1'b0;
      isr_level <= 3'd0;
      cas_out   <= CAS_IDLE;
      pending   <= 1'b0;
      selected  <= 1'b0;
      tcount    <= '0;
`ifdef PIC_AEOI_EN
      eoi_pulse <= 1'b0;
`endif
    end else begin
      isr_set <= 1'b0;
      abort   <= 1'b0;
`ifdef PIC_AEOI_EN
      eoi_pulse <= 1'b0;
`endif
      case (state)
        IDLE: begin
          tcount <= '0;
          if (irq_valid) begin
            state <= REQ;
            intr  <= 1'b1;
          end
        end
        REQ: begin
          tcount <= '0;
          if (fall) begin
            state     <= ACK1;
            intr      <= 1'b0;
            freeze    <= 1'b1;
            isr_level <= new_level;
            pending   <= irq_valid;
            isr_set   <= irq_valid;
            selected  <= (cas_in == icw3[2:0]);
            cas_out   <= new_cas;
          end
        end
        default: begin
          if (fall | rise) begin
            tcount  <= '0;
            cas_out <= cur_cas;
            case (state)
              ACK1: if (rise) state <= GAP;
              GAP: if (fall) begin
                state   <= ACK2;
                data_oe <= responder;
              end
              ACK2: if (rise) begin
                state   <= IDLE;
                freeze  <= 1'b0;
                data_oe <= 1'b0;
                cas_out <= CAS_IDLE;
`ifdef PIC_AEOI_EN
                eoi_pulse <= aeoi & pending;
`endif
              end
              default: ;
            endcase
          end else if (tcount == CNT_LAST) begin
            // Host never completed the handshake; ISR stays set for firmware to clean up.
            state   <= IDLE;
            abort   <= 1'b1;
            freeze  <= 1'b0;
            data_oe <= 1'b0;
            cas_out <= CAS_IDLE;
            tcount  <= '0;
          end else begin
            tcount  <= tcount + 1'b1;
            cas_out <= cur_cas;
            if (state == ACK2) data_oe <= responder;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cascade_inta_sequencer.sv
// Scoreboard bench for cascade_inta_sequencer: driver pushes expected handshake results, monitor checks them.
module tb_cascade_inta_sequencer;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sp = 1'b0;
  logic       sngl = 1'b1;
  logic [7:0] icw3 = 8'h00;
  logic       irq_valid = 1'b0;
  logic [2:0] irq_level = 3'd0;
  logic       inta_n = 1'b1;
  logic [2:0] cas_in = 3'd0;
  logic [2:0] cas_out, isr_level;
  logic       cas_oe, intr, freeze, isr_set, data_oe, abort;
`ifdef PIC_AEOI_EN
  logic       aeoi = 1'b1;
  logic       eoi_pulse;
`endif

  always #5 clk = ~clk;

  cascade_inta_sequencer #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sp        (sp),
    .sngl      (sngl),
    .icw3      (icw3),
    .irq_valid (irq_valid),
    .irq_level (irq_level),
    .inta_n    (inta_n),
    .cas_in    (cas_in),
    .cas_out   (cas_out),
    .cas_oe    (cas_oe),
    .intr      (intr),
    .freeze    (freeze),
    .isr_set   (isr_set),
    .isr_level (isr_level),
    .data_oe   (data_oe),
    .abort     (abort)
`ifdef PIC_AEOI_EN
    ,
    .aeoi      (aeoi),
    .eoi_pulse (eoi_pulse)
`endif
  );

  typedef struct {
    int level;
    int set_cnt;
    int cas;
    bit oe;
    bit drive;
    bit abrt;
    bit eoi;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   skip_win = 1'b0;
  bit   second_fall = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return intr;
      1:       return freeze;
      default: return data_oe;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, input bit val, input int budget);
    int n = 0;
    while (sig(which) != val && n < budget) begin
      tick(1);
      n++;
    end
    check(name, int'(sig(which)), int'(val));
  endtask

  // mode: 0 single, 1 cascade master, 2 cascade slave; ab: 0 none, 1 stall after first pulse, 2 stall in second pulse
  function automatic exp_t model(input int mode, input bit [7:0] c3, input int lvl, input bit spur,
                                 input bit [2:0] cin, input int ab);
    exp_t e;
    e.level   = spur ? 7 : lvl;
    e.set_cnt = spur ? 0 : 1;
    e.cas     = 0;
    e.oe      = (mode == 1);
    e.abrt    = (ab != 0);
    e.eoi     = !spur && ab == 0;
    case (mode)
      0: e.drive = 1'b1;
      1: begin
        if (c3[e.level]) begin
          e.cas   = e.level;
          e.drive = 1'b0;
        end else begin
          e.drive = 1'b1;
        end
      end
      default: e.drive = !spur && (cin == c3[2:0]);
    endcase
    if (ab == 1) e.drive = 1'b0;
    return e;
  endfunction

  task automatic run_txn(input int mode, input bit [7:0] c3, input int lvl, input bit spur,
                         input bit [2:0] cin, input int ab, input int low1, input int gap,
                         input int low2, input bit pre_low);
    sp          = (mode == 1) ? 1'b1 : (mode == 0 ? 1'($urandom_range(0, 1)) : 1'b0);
    sngl        = (mode == 0);
    icw3        = c3;
    cas_in      = cin;
    irq_level   = 3'(lvl);
    second_fall = 1'b0;
    tick(2);
    sb.push_back(model(mode, c3, lvl, spur, cin, ab));
    if (pre_low) begin
      inta_n = 1'b0;
      tick(6);
      check("idle_fall_ignored_freeze", int'(freeze), 0);
      check("idle_fall_ignored_int", int'(intr), 0);
    end
    irq_valid = 1'b1;
    wait_sig("int_raise", 0, 1'b1, 6);
    if (pre_low) begin
      inta_n = 1'b1;
      tick(6);
      check("req_rise_ignored_freeze", int'(freeze), 0);
      check("req_rise_ignored_int", int'(intr), 1);
    end
    if (spur) begin
      irq_valid = 1'b0;
      irq_level = 3'($urandom_range(0, 7));
      tick(3);
      check("int_held_in_req", int'(intr), 1);
    end
    inta_n = 1'b0;
    tick(low1);
    inta_n = 1'b1;
    wait_sig("freeze_on", 1, 1'b1, 8);
    irq_valid = 1'b0;
    if (ab == 1) begin
      tick(TO + 20);
    end else begin
      tick(gap);
      inta_n = 1'b0;
      second_fall = 1'b1;
      tick(ab == 2 ? TO + 20 : low2);
      inta_n = 1'b1;
    end
    wait_sig("freeze_off", 1, 1'b0, 12);
    tick($urandom_range(1, 4));
  endtask

  // Monitor: collects what the DUT did inside each FREEZE window and compares at window end.
  initial begin
    bit   prev_f = 1'b0, in_win = 1'b0, w_cas_bad, w_drive, w_oe;
    int   w_level, w_set, w_cas;
    exp_t e;
    forever begin
      @(negedge clk);
      if (freeze && !prev_f) begin
        in_win    = 1'b1;
        w_level   = isr_level;
        w_cas     = cas_out;
        w_oe      = cas_oe;
        w_cas_bad = 1'b0;
        w_drive   = 1'b0;
        w_set     = 0;
      end
      if (in_win && freeze) begin
        w_set += int'(isr_set);
        if (cas_out != 3'(w_cas)) w_cas_bad = 1'b1;
        if (data_oe) begin
          if (!w_drive) check("data_oe_after_second_fall", int'(second_fall), 1);
          w_drive = 1'b1;
        end
      end else if (isr_set) begin
        check("isr_set_outside_window", int'(isr_set), 0);
      end
      if (!freeze && prev_f && in_win) begin
        in_win = 1'b0;
        if (!skip_win) begin
          if (sb.size() == 0) begin
            check("scoreboard_has_entry", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("isr_level", w_level, e.level);
            check("isr_set_count", w_set, e.set_cnt);
            check("cas_out", w_cas, e.cas);
            check("cas_out_stable", int'(w_cas_bad), 0);
            check("cas_oe", int'(w_oe), int'(e.oe));
            check("data_oe_driven", int'(w_drive), int'(e.drive));
            check("abort", int'(abort), int'(e.abrt));
            check("data_oe_exit", int'(data_oe), 0);
            check("cas_out_exit", int'(cas_out), 0);
            check("int_exit", int'(intr), 0);
`ifdef PIC_AEOI_EN
            check("eoi_pulse", int'(eoi_pulse), int'(e.eoi));
`endif
          end
        end
      end
      prev_f = freeze;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, lvl, ab;
    bit [7:0] c3;
    bit [2:0] cin;
    bit spur;

    tick(3);
    check("rst_int", int'(intr), 0);
    check("rst_freeze", int'(freeze), 0);
    check("rst_data_oe", int'(data_oe), 0);
    check("rst_isr_level", int'(isr_level), 0);
    check("rst_cas_out", int'(cas_out), 0);
    check("rst_abort", int'(abort), 0);
    rst_n = 1'b1;
    tick(2);

    run_txn(0, 8'h00, 5, 1'b0, 3'd0, 0, 3, 3, 3, 1'b1);
    run_txn(1, 8'h09, 3, 1'b0, 3'd0, 0, 2, 4, 2, 1'b0);
    run_txn(2, 8'h03, 3, 1'b0, 3'd3, 0, 2, 4, 2, 1'b0);
    run_txn(2, 8'h00, 3, 1'b0, 3'd3, 0, 2, 4, 2, 1'b0);
    run_txn(1, 8'h09, 1, 1'b0, 3'd0, 0, 1, 1, 1, 1'b0);
    run_txn(0, 8'h00, 4, 1'b1, 3'd0, 0, 2, 3, 2, 1'b0);
    run_txn(1, 8'h80, 2, 1'b1, 3'd0, 0, 2, 3, 2, 1'b0);
    run_txn(1, 8'h09, 3, 1'b0, 3'd0, 1, 2, 3, 2, 1'b0);
    run_txn(0, 8'h00, 6, 1'b0, 3'd0, 2, 2, 3, 2, 1'b0);
    run_txn(0, 8'h00, 2, 1'b0, 3'd0, 0, 2, TO - 12, 2, 1'b0);

    // Asynchronous reset while in ACK2
    skip_win  = 1'b1;
    sp        = 1'b0;
    sngl      = 1'b1;
    irq_level = 3'd6;
    irq_valid = 1'b1;
    wait_sig("rst_seq_int", 0, 1'b1, 6);
    inta_n = 1'b0;
    tick(2);
    inta_n = 1'b1;
    wait_sig("rst_seq_freeze", 1, 1'b1, 8);
    irq_valid = 1'b0;
    tick(3);
    inta_n = 1'b0;
    second_fall = 1'b1;
    wait_sig("rst_seq_data_oe", 2, 1'b1, 10);
    rst_n = 1'b0;
    #1;
    check("midrst_int", int'(intr), 0);
    check("midrst_freeze", int'(freeze), 0);
    check("midrst_data_oe", int'(data_oe), 0);
    check("midrst_isr_level", int'(isr_level), 0);
    check("midrst_cas_out", int'(cas_out), 0);
    check("midrst_isr_set", int'(isr_set), 0);
    inta_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    skip_win = 1'b0;

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      c3   = 8'($urandom);
      lvl  = $urandom_range(0, 7);
      spur = ($urandom_range(0, 4) == 0);
      cin  = $urandom_range(0, 1) ? c3[2:0] : 3'($urandom_range(0, 7));
      ab   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      run_txn(mode, c3, lvl, spur, cin, ab, $urandom_range(1, 5), $urandom_range(1, 8),
              $urandom_range(1, 5), 1'b0);
    end

    tick(5);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
